// File: rtl/hex_page_debugger_pkg.sv
// Shared constants and helpers for the paged hex debug viewer:
// 7-segment codes, a constant-safe clog2 and the hex-to-segment decode.
package hex_page_debugger_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  // Counter/index width that never collapses to zero bits
  function automatic int width_of(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    case (nibble)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/hex_page_debugger_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle
// pulse on each accepted rising edge of the debounced level.
module hex_page_debugger_debounce
  import hex_page_debugger_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = width_of(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [1:0]    sync_reg;
  logic          level_reg;
  logic [CW-1:0] cnt_reg;
  logic          pulse_reg;
  logic          accept;

  // The counter only runs while the synchronised sample disagrees with the
  // accepted level; any agreeing sample restarts the stability window.
  assign accept = (sync_reg[1] != level_reg) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
      pulse_reg <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], btn};
      pulse_reg <= accept && sync_reg[1];
      if (sync_reg[1] == level_reg) begin
        cnt_reg <= '0;
      end else if (accept) begin
        level_reg <= sync_reg[1];
        cnt_reg   <= '0;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/hex_page_debugger.sv
// Paged 7-segment viewer for a wide debug bus: button/auto page navigation,
// freeze snapshot and a registered hex display of the selected page.
module hex_page_debugger
  import hex_page_debugger_pkg::*;
#(
  parameter  int DEBUG_W      = 128,
  parameter  int DIGITS       = 8,
  parameter  int DEBOUNCE_CYC = 500_000,
  parameter  int AUTO_DIV     = 50_000_000,
  localparam int PAGE_BITS    = 4 * DIGITS,
  localparam int PAGES        = (DEBUG_W + PAGE_BITS - 1) / PAGE_BITS,
  localparam int PG_W         = width_of(PAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DEBUG_W-1:0]    debug,
  input  logic                  btn_next,
  input  logic                  btn_prev,
  input  logic                  btn_hold,
  input  logic                  auto_en,
  output logic [7*DIGITS-1:0]   hex_seg,
  output logic [PG_W-1:0]       page_idx,
  output logic                  hold_on
);

  localparam int SRC_W = PAGES * PAGE_BITS;
  localparam int TW    = width_of(AUTO_DIV);
  localparam logic [TW-1:0]   AUTO_LAST = TW'(AUTO_DIV - 1);
  localparam logic [PG_W-1:0] PAGE_LAST = PG_W'(PAGES - 1);

  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;
  logic       next_p, prev_p, hold_p;

  assign btn_raw = {btn_hold, btn_prev, btn_next};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      hex_page_debugger_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_raw[gi]),
        .pulse (btn_pulse[gi])
      );
    end
  endgenerate

  assign next_p = btn_pulse[0];
  assign prev_p = btn_pulse[1];
  assign hold_p = btn_pulse[2];

  logic [PG_W-1:0]      page_reg, page_next;
  logic [TW-1:0]        timer_reg, timer_next;
  logic                 hold_on_reg;
  logic [DEBUG_W-1:0]   snapshot_reg;
  logic [7*DIGITS-1:0]  hex_seg_reg, hex_seg_next;
  logic                 manual, auto_tc, step_fwd, step_bwd;

  // A manual press on the terminal cycle swallows the auto step
  assign manual   = next_p | prev_p;
  assign auto_tc  = auto_en && !hold_on_reg && (timer_reg == AUTO_LAST);
  assign step_fwd = (next_p && !prev_p) || (auto_tc && !manual);
  assign step_bwd = prev_p && !next_p;

  always_comb begin
    page_next = page_reg;
    if (step_fwd) begin
      page_next = (page_reg == PAGE_LAST) ? '0 : page_reg + 1'b1;
    end else if (step_bwd) begin
      page_next = (page_reg == '0) ? PAGE_LAST : page_reg - 1'b1;
    end
  end

  always_comb begin
    timer_next = timer_reg + 1'b1;
    if (!auto_en || hold_on_reg || manual || auto_tc) begin
      timer_next = '0;
    end
  end

  logic [DEBUG_W-1:0]   src;
  logic [SRC_W-1:0]     src_ext;
  logic [PAGE_BITS-1:0] page_words [PAGES];
  logic [PAGE_BITS-1:0] cur_page;

  always_comb begin
    src_ext              = '0;
    src_ext[DEBUG_W-1:0] = src;
  end

  assign src = hold_on_reg ? snapshot_reg : debug;

  generate
    for (gi = 0; gi < PAGES; gi++) begin : g_page
      assign page_words[gi] = src_ext[gi*PAGE_BITS +: PAGE_BITS];
    end
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign hex_seg_next[7*gi +: 7] = hex_to_seg(cur_page[4*gi +: 4]);
    end
  endgenerate

  assign cur_page = page_words[page_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_reg     <= '0;
      timer_reg    <= '0;
      hold_on_reg  <= 1'b0;
      snapshot_reg <= '0;
      hex_seg_reg  <= '1;
    end else begin
      page_reg    <= page_next;
      timer_reg   <= timer_next;
      hex_seg_reg <= hex_seg_next;
      if (hold_p) begin
        hold_on_reg <= !hold_on_reg;
        if (!hold_on_reg) begin
          snapshot_reg <= debug;
        end
      end
    end
  end

  assign hex_seg  = hex_seg_reg;
  assign page_idx = page_reg;
  assign hold_on  = hold_on_reg;

endmodule

// File: tb/tb_hex_page_debugger.sv
// Directed + randomized bench for hex_page_debugger against a page/display
// model computed from bus arithmetic; one line per checked transaction.
module tb_hex_page_debugger;

  logic         clk;
  logic         rst_n;
  logic [127:0] debug;
  logic         btn_next, btn_prev, btn_hold, auto_en;
  logic [55:0]  hex_seg;
  logic [1:0]   page_idx;
  logic         hold_on;

  logic [39:0]  debug2;
  logic         btn_next2;
  logic         tie0;
  logic [55:0]  hex_seg2;
  logic [0:0]   page_idx2;
  logic         hold_on2;

  int errors = 0;
  int checks = 0;

  int           page_m;
  int           page2_m;
  logic [127:0] snap_m;
  int           n;
  int           n2;

  hex_page_debugger #(
    .DEBUG_W(128), .DIGITS(8), .DEBOUNCE_CYC(4), .AUTO_DIV(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .debug(debug),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_hold(btn_hold),
    .auto_en(auto_en), .hex_seg(hex_seg), .page_idx(page_idx), .hold_on(hold_on)
  );

  hex_page_debugger #(
    .DEBUG_W(40), .DIGITS(8), .DEBOUNCE_CYC(4), .AUTO_DIV(16)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .debug(debug2),
    .btn_next(btn_next2), .btn_prev(tie0), .btn_hold(tie0),
    .auto_en(tie0), .hex_seg(hex_seg2), .page_idx(page_idx2), .hold_on(hold_on2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int v);
    case (v)
      0: return 7'h40;   1: return 7'h79;   2: return 7'h24;   3: return 7'h30;
      4: return 7'h19;   5: return 7'h12;   6: return 7'h02;   7: return 7'h78;
      8: return 7'h00;   9: return 7'h10;  10: return 7'h08;  11: return 7'h03;
      12: return 7'h46; 13: return 7'h21;  14: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Expected display: nibble n of page p sits at bit (p*8+n)*4; past the bus width it reads 0
  function automatic logic [55:0] exp_hex(input logic [127:0] src, input int page, input int width);
    logic [55:0]  res;
    logic [127:0] sh;
    int           pos;
    int           nib;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      pos = (page * 8 + k) * 4;
      nib = 0;
      if (pos < width) begin
        sh  = src >> pos;
        nib = int'(sh[3:0]);
      end
      res[7*k +: 7] = seg_of(nib);
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %-16s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  // which: 0 next, 1 prev, 2 hold, 3 next+prev together, 4 next on dut2
  task automatic press(input int which);
    @(negedge clk);
    case (which)
      0: btn_next = 1'b1;
      1: btn_prev = 1'b1;
      2: btn_hold = 1'b1;
      3: begin btn_next = 1'b1; btn_prev = 1'b1; end
      default: btn_next2 = 1'b1;
    endcase
    cycles(10);
    btn_next = 1'b0; btn_prev = 1'b0; btn_hold = 1'b0; btn_next2 = 1'b0;
    cycles(12);
  endtask

  // Counts negedges until page_idx moves; capped so a stuck design still finishes
  task automatic wait_change(output int cnt);
    logic [1:0] last;
    last = page_idx;
    cnt  = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (page_idx == last && cnt < 40);
  endtask

  initial begin
    rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; btn_hold = 1'b0; auto_en = 1'b0;
    btn_next2 = 1'b0; tie0 = 1'b0;
    debug  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    debug2 = 40'hA5_1234_5678;
    page_m = 0; page2_m = 0; snap_m = '0;

    // 1. reset values and first frame
    cycles(3);
    check("rst_hex", 64'(hex_seg), {8'h0, {56{1'b1}}});
    check("rst_page", 64'(page_idx), 64'd0);
    check("rst_hold", 64'(hold_on), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("first_frame", 64'(hex_seg), 64'(exp_hex(debug, 0, 128)));
    check("digit0_nib0", 64'(hex_seg[6:0]), 64'h40);

    // 2. bounce then long press gives one step; wrap 3 -> 0
    @(negedge clk) btn_next = 1'b1;
    @(negedge clk) btn_next = 1'b0;
    @(negedge clk) btn_next = 1'b1;
    cycles(10);
    btn_next = 1'b0;
    cycles(12);
    page_m = 1;
    check("bounce_step", 64'(page_idx), 64'(page_m));
    check("page1_hex", 64'(hex_seg), 64'(exp_hex(debug, 1, 128)));
    press(0); press(0); page_m = 3;
    check("page3", 64'(page_idx), 64'(page_m));
    press(0); page_m = 0;
    check("wrap_next", 64'(page_idx), 64'(page_m));

    // random navigation with random bus contents
    for (int t = 0; t < 6; t++) begin
      int which;
      debug = {$urandom, $urandom, $urandom, $urandom};
      which = int'($urandom_range(0, 1));
      press(which);
      page_m = (which == 0) ? (page_m + 1) % 4 : (page_m + 3) % 4;
      check("rand_page", 64'(page_idx), 64'(page_m));
      check("rand_hex", 64'(hex_seg), 64'(exp_hex(debug, page_m, 128)));
    end

    // 3. prev wraps 0 -> 3; simultaneous next+prev holds page
    while (page_m != 0) begin
      press(0);
      page_m = (page_m + 1) % 4;
    end
    press(1); page_m = 3;
    check("wrap_prev", 64'(page_idx), 64'(page_m));
    press(3);
    check("both_btn", 64'(page_idx), 64'(page_m));

    // 4. auto scroll every 16 cycles, manual step restarts the timer
    auto_en = 1'b1;
    wait_change(n);
    page_m = (page_m + 1) % 4;
    check("auto_first", 64'(page_idx), 64'(page_m));
    for (int t = 0; t < 2; t++) begin
      wait_change(n);
      page_m = (page_m + 1) % 4;
      check("auto_period", 64'(n), 64'd16);
      check("auto_page", 64'(page_idx), 64'(page_m));
    end
    cycles(2);
    btn_next = 1'b1;
    wait_change(n2);
    page_m = (page_m + 1) % 4;
    check("manual_early", 64'(n2 + 2 < 16), 64'd1);
    check("manual_page", 64'(page_idx), 64'(page_m));
    wait_change(n);
    page_m = (page_m + 1) % 4;
    check("auto_restart", 64'(n), 64'd16);
    check("no_double", 64'(page_idx), 64'(page_m));
    auto_en  = 1'b0;
    btn_next = 1'b0;
    cycles(12);

    // 5. hold freezes display, navigation still works, auto suspended
    debug = {$urandom, $urandom, $urandom, $urandom};
    press(2);
    snap_m = debug;
    check("hold_on", 64'(hold_on), 64'd1);
    debug = ~debug ^ {$urandom, $urandom, $urandom, $urandom};
    cycles(2);
    check("hold_hex", 64'(hex_seg), 64'(exp_hex(snap_m, page_m, 128)));
    press(0); page_m = (page_m + 1) % 4;
    check("hold_nav_page", 64'(page_idx), 64'(page_m));
    check("hold_nav_hex", 64'(hex_seg), 64'(exp_hex(snap_m, page_m, 128)));
    auto_en = 1'b1;
    cycles(40);
    check("hold_no_auto", 64'(page_idx), 64'(page_m));
    auto_en = 1'b0;
    press(2);
    check("unhold", 64'(hold_on), 64'd0);
    check("live_hex", 64'(hex_seg), 64'(exp_hex(debug, page_m, 128)));

    // 6. narrow bus: page 1 digits past bit 39 read zero
    debug2 = {$urandom, $urandom};
    press(4); page2_m = 1;
    check("n_page", 64'(page_idx2), 64'(page2_m));
    check("n_hex", 64'(hex_seg2), 64'(exp_hex({88'h0, debug2}, 1, 40)));
    check("n_zero_digits", 64'(hex_seg2[55:14]), 64'({6{7'h40}}));
    press(4); page2_m = 0;
    check("n_wrap", 64'(page_idx2), 64'(page2_m));
    check("n_hex0", 64'(hex_seg2), 64'(exp_hex({88'h0, debug2}, 0, 40)));

    // async reset mid-debounce and mid-auto
    if (page_m == 0) begin
      press(0);
      page_m = 1;
    end
    auto_en  = 1'b1;
    btn_next = 1'b1;
    cycles(3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_page", 64'(page_idx), 64'd0);
    check("mid_rst_hex", 64'(hex_seg), {8'h0, {56{1'b1}}});
    check("mid_rst_hold", 64'(hold_on), 64'd0);
    btn_next = 1'b0;
    auto_en  = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    page_m = 0;
    cycles(20);
    check("post_rst_page", 64'(page_idx), 64'(page_m));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
